// File: rtl/decoder_nota_sustentado.sv
// Registered note decoder with per-note sustain counters (polyphonic by default).
// Define NOTA_MONO_EN for monophonic, last-note-priority behaviour.
module decoder_nota_sustentado #(
    parameter int NUM_NOTES   = 12,
    parameter int IDX_W       = 4,
    parameter int HOLD_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [IDX_W-1:0]                   valor,
    input  logic                               valor_valid,
    input  logic                               soltar,
    output logic [NUM_NOTES-1:0]               nota,
    output logic                               ativo,
    output logic [$clog2(NUM_NOTES+1)-1:0]     n_ativas,
    output logic                               erro
);

    localparam int NW = $clog2(NUM_NOTES + 1);

    logic [CNT_W-1:0]     r_cnt     [NUM_NOTES];
    logic [CNT_W-1:0]     w_cntNext [NUM_NOTES];
    logic [NUM_NOTES-1:0] w_notaNext;
    logic [NW-1:0]        w_count;
    logic                 w_legal;
    logic                 w_outOfRange;

    // Release/disable clears first, then a legal strobe loads its counter.
    always_comb begin
        w_legal      = valor_valid && enable && (32'(valor) < 32'(NUM_NOTES));
        w_outOfRange = valor_valid && enable && (32'(valor) >= 32'(NUM_NOTES));
        w_notaNext   = '0;
        w_count      = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            w_cntNext[i] = '0;
            if (enable && !soltar && (r_cnt[i] != '0)) begin
                w_cntNext[i] = r_cnt[i] - CNT_W'(1);
            end
`ifdef NOTA_MONO_EN
            if (w_legal) begin
                w_cntNext[i] = '0;
            end
`endif
            if (w_legal && (32'(valor) == 32'(i))) begin
                w_cntNext[i] = CNT_W'(HOLD_CYCLES);
            end
            w_notaNext[i] = (w_cntNext[i] != '0);
            w_count       = w_count + NW'(w_notaNext[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                r_cnt[i] <= '0;
            end
            nota     <= '0;
            ativo    <= 1'b0;
            n_ativas <= '0;
            erro     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                r_cnt[i] <= w_cntNext[i];
            end
            nota     <= w_notaNext;
            ativo    <= |w_notaNext;
            n_ativas <= w_count;
            erro     <= w_outOfRange;
        end
    end

endmodule

// File: tb/tb_decoder_nota_sustentado.sv
// Scoreboard bench for decoder_nota_sustentado (NUM_NOTES=12, HOLD_CYCLES=4).
module tb_decoder_nota_sustentado;

    localparam int NUM_NOTES   = 12;
    localparam int IDX_W       = 4;
    localparam int HOLD_CYCLES = 4;
    localparam int CNT_W       = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  valor = '0;
    logic        valorValid = 1'b0;
    logic        soltar = 1'b0;
    logic [11:0] nota;
    logic        ativo;
    logic [3:0]  nAtivas;
    logic        erro;

    typedef struct {
        logic [11:0] nota;
        logic        ativo;
        logic [3:0]  nAtivas;
        logic        erro;
    } expected_t;

    expected_t expQueue[$];
    int        endCyc [NUM_NOTES];
    int        cyc = 0;
    int        checks = 0;
    int        errors = 0;

    decoder_nota_sustentado #(
        .NUM_NOTES(NUM_NOTES), .IDX_W(IDX_W), .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .valor(valor),
        .valor_valid(valorValid), .soltar(soltar), .nota(nota), .ativo(ativo),
        .n_ativas(nAtivas), .erro(erro)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Model keeps an absolute end-cycle per note; a note sounds while cyc < endCyc.
    task automatic applyStimulus(input logic en, input logic vv, input logic [3:0] val, input logic sol);
        expected_t e;
        expected_t got;
        logic [11:0] mask;
        @(negedge clock);
        enable = en; valorValid = vv; valor = val; soltar = sol;
        @(posedge clock);
        cyc++;
        if (!en || sol) begin
            for (int i = 0; i < NUM_NOTES; i++) endCyc[i] = 0;
        end
        if (en && vv && val < NUM_NOTES) begin
`ifdef NOTA_MONO_EN
            for (int i = 0; i < NUM_NOTES; i++) endCyc[i] = 0;
`endif
            endCyc[val] = cyc + HOLD_CYCLES;
        end
        mask = '0;
        for (int i = 0; i < NUM_NOTES; i++) mask[i] = (endCyc[i] > cyc);
        e.nota    = mask;
        e.ativo   = (mask != 0);
        e.nAtivas = 4'($countones(mask));
        e.erro    = en && vv && (val >= NUM_NOTES);
        expQueue.push_back(e);
        #1;
        got = expQueue.pop_front();
        checkOutput("nota", 64'(nota), 64'(got.nota));
        checkOutput("ativo", 64'(ativo), 64'(got.ativo));
        checkOutput("n_ativas", 64'(nAtivas), 64'(got.nAtivas));
        checkOutput("erro", 64'(erro), 64'(got.erro));
        enable = en; valorValid = 1'b0; soltar = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NUM_NOTES; i++) endCyc[i] = 0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_nota", 64'(nota), 64'h0);
        checkOutput("reset_ativo", 64'(ativo), 64'h0);
        checkOutput("reset_n_ativas", 64'(nAtivas), 64'h0);
        checkOutput("reset_erro", 64'(erro), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        enable = 1'b1;

        $display("[TB] idle after reset");
        idle(3);

        $display("[TB] single note sustain");
        applyStimulus(1'b1, 1'b1, 4'd5, 1'b0);
        checkOutput("note5_mask", 64'(nota), 64'h020);
        idle(5);

        $display("[TB] two overlapping notes");
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b0);
        idle(1);
        applyStimulus(1'b1, 1'b1, 4'd11, 1'b0);
`ifdef NOTA_MONO_EN
        checkOutput("overlap_mask", 64'(nota), 64'h800);
`else
        checkOutput("overlap_mask", 64'(nota), 64'h801);
        checkOutput("overlap_count", 64'(nAtivas), 64'd2);
`endif
        idle(5);

        $display("[TB] retrigger");
        applyStimulus(1'b1, 1'b1, 4'd3, 1'b0);
        idle(1);
        applyStimulus(1'b1, 1'b1, 4'd3, 1'b0);
        idle(3);
        checkOutput("retrig_held", 64'(nota[3]), 64'h1);
        idle(1);
        checkOutput("retrig_end", 64'(nota[3]), 64'h0);

        $display("[TB] out of range indices");
        applyStimulus(1'b1, 1'b1, 4'd2, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd12, 1'b0);
        checkOutput("oor12_erro", 64'(erro), 64'h1);
        applyStimulus(1'b1, 1'b1, 4'd15, 1'b0);
        idle(1);
        checkOutput("oor_erro_clear", 64'(erro), 64'h0);
        applyStimulus(1'b0, 1'b1, 4'd12, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd15, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd4, 1'b0);
        idle(2);

        $display("[TB] release with simultaneous strobe");
        applyStimulus(1'b1, 1'b1, 4'd2, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd9, 1'b1);
        checkOutput("soltar_mask", 64'(nota), 64'h200);

        $display("[TB] asynchronous reset mid-sustain");
        #2 reset = 1'b0;
        #1;
        checkOutput("async_nota", 64'(nota), 64'h0);
        checkOutput("async_ativo", 64'(ativo), 64'h0);
        checkOutput("async_n_ativas", 64'(nAtivas), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < NUM_NOTES; i++) endCyc[i] = 0;
        applyStimulus(1'b1, 1'b1, 4'd1, 1'b0);
        idle(4);

        $display("[TB] random traffic");
        for (int k = 0; k < 60; k++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                          4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
